cla_serial_adder: RTL and testbench

CLA_SERIAL_ADDER -- requirements
Module: cla_serial_adder

---
 rtl/cla_pkg.sv | 14 +
 rtl/cla_block.sv | 67 ++++++
 rtl/cla_serial_adder.sv | 119 +++++++++++
 tb/tb_cla_serial_adder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared state type and default geometry for the serial CLA adder
package cla_pkg;

    // Operand/result width and slice width used when a parent does not override them.
    localparam int CLA_WIDTH = 16;
    localparam int CLA_BLOCK = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cla_state_t;

endpackage

// File: rtl/cla_block.sv
// rtl/cla_block.sv - combinational BLOCK-bit carry-lookahead slice
//
// Ports:
//   a, b    slice operand bits
//   cin     carry into bit 0 of the slice
//   s       slice sum
//   cout    carry out of the slice MSB
//   c_msb   carry into the slice MSB (used for overflow)
//   grp_g   group generate: slice produces a carry regardless of cin
//   grp_p   group propagate: AND of all bit propagates
module cla_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout,
    output logic             c_msb,
    output logic             grp_g,
    output logic             grp_p
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry c[i] is built as an OR of product terms:
    //   (p[i-1]&...&p[0]&cin) | OR_j (g[j] & p[i-1]&...&p[j+1])
    // The loops only enumerate the terms; the resulting logic is two-level.
    always_comb begin : lookahead
        logic term;
        term  = 1'b0;
        c     = '0;
        grp_g = 1'b0;
        for (int i = 0; i <= BLOCK; i++) begin
            term = cin;
            for (int k = 0; k < i; k++) begin
                term = term & p[k];
            end
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & p[k];
                end
                c[i] = c[i] | term;
            end
        end
        for (int j = 0; j < BLOCK; j++) begin
            term = g[j];
            for (int k = j + 1; k < BLOCK; k++) begin
                term = term & p[k];
            end
            grp_g = grp_g | term;
        end
    end

    assign grp_p = &p;
    assign s     = p ^ c[BLOCK-1:0];
    assign cout  = c[BLOCK];
    assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/cla_serial_adder.sv
// rtl/cla_serial_adder.sv - multi-cycle adder/subtractor, one lookahead slice per cycle
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request, accepted only in IDLE
//   sub, cin, a, b    mode, carry-in and operands, sampled with start
//   busy              high while slices are being processed
//   done              one-cycle result-valid pulse
//   sum, cout, ovf    result, carry out (no-borrow in sub mode), signed overflow
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / BLOCK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    cla_state_t       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [BLOCK-1:0] sl_a;
    logic [BLOCK-1:0] sl_b;
    logic [BLOCK-1:0] sl_s;
    logic             sl_cout;
    logic             sl_cmsb;
    logic             sl_g;
    logic             sl_p;

    assign sl_a = a_q[idx*BLOCK +: BLOCK];
    assign sl_b = b_q[idx*BLOCK +: BLOCK];

    cla_block #(
        .BLOCK (BLOCK)
    ) u_block (
        .a     (sl_a),
        .b     (sl_b),
        .cin   (carry),
        .s     (sl_s),
        .cout  (sl_cout),
        .c_msb (sl_cmsb),
        .grp_g (sl_g),
        .grp_p (sl_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b now, seed carry with 1.
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum[idx*BLOCK +: BLOCK] <= sl_s;
                    // Slice carry-out expressed through the group terms.
                    carry <= sl_g | (sl_p & carry);
                    idx   <= idx + 1'b1;
                    if (idx == IDX_W'(N - 1)) begin
                        cout  <= sl_cout;
                        ovf   <= sl_cout ^ sl_cmsb;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_adder.sv
// tb/tb_cla_serial_adder.sv - randomized self-checking bench for cla_serial_adder
module tb_cla_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int tests;
    int fails;

    cla_serial_adder #(
        .WIDTH (16),
        .BLOCK (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic msub, input logic mcin);
        logic [16:0] full;
        logic [15:0] s;
        logic        co;
        logic        ov;
        if (!msub) begin
            full = 17'(ma) + 17'(mb) + 17'(mcin);
            s    = full[15:0];
            co   = full[16];
            ov   = (ma[15] == mb[15]) && (s[15] != ma[15]);
        end else begin
            s  = ma - mb;
            co = (ma >= mb);
            ov = (ma[15] != mb[15]) && (s[15] != ma[15]);
        end
        return {ov, co, s};
    endfunction

    // Waits for an idle cycle, issues one request, scrambles the inputs after
    // acceptance, and returns the result seen in the done cycle.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                          input logic isub, input logic icin,
                          output logic [15:0] osum, output logic ocout, output logic oovf,
                          output int lat, output int bcnt, output int waits);
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while ((busy || done) && waits < 40);
        a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        sub = 1'($urandom); cin = 1'($urandom);
        lat = 0;
        bcnt = 0;
        while (lat < 20) begin
            lat++;
            if (busy) bcnt++;
            if (done) break;
            @(posedge clk);
            #1;
        end
        osum = sum; ocout = cout; oovf = ovf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, sum, cout, ovf} !== 19'd0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            tests++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL idle_no_start: got busy=%b done=%b, want 0 0", busy, done);
            end
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic        vs [6];
        logic        vc [6];
        logic [15:0] exp_s [6];
        logic        exp_c [6];
        logic        exp_o [6];
        logic [15:0] gs;
        logic        gc;
        logic        go;
        int          lat;
        int          bc;
        int          w;
        va = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h8000};
        vb = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h8000};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_s = '{16'h0100, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
        exp_c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_o = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vs[i], vc[i], gs, gc, go, lat, bc, w);
            tests++;
            if (gs !== exp_s[i] || gc !== exp_c[i] || go !== exp_o[i]) begin
                fails++;
                $display("FAIL directed_%0d: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, gs, gc, go, exp_s[i], exp_c[i], exp_o[i]);
            end
            tests++;
            if (lat != 5 || bc != 4) begin
                fails++;
                $display("FAIL directed_timing_%0d: got done_cycle=%0d busy_cycles=%0d, want 5 4",
                         i, lat, bc);
            end
            @(posedge clk);
            #1;
            tests++;
            if (done !== 1'b0 || sum !== exp_s[i]) begin
                fails++;
                $display("FAIL directed_hold_%0d: got done=%b sum=%h, want done=0 sum=%h",
                         i, done, sum, exp_s[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        logic        rc;
        logic [17:0] exp;
        logic [15:0] gs;
        logic        gc;
        logic        go;
        int          lat;
        int          bc;
        int          w;
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            exp = model(ra, rb, rs, rc);
            run_op(ra, rb, rs, rc, gs, gc, go, lat, bc, w);
            tests++;
            if ({go, gc, gs} !== exp || lat != 5) begin
                fails++;
                $display("FAIL random_%0d: a=%h b=%h sub=%b cin=%b got sum=%h cout=%b ovf=%b lat=%0d, want sum=%h cout=%b ovf=%b lat=5",
                         i, ra, rb, rs, rc, gs, gc, go, lat, exp[15:0], exp[16], exp[17]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp;
        logic [15:0] gs;
        logic        gc;
        logic        go;
        int          lat;
        int          bc;
        int          w;
        run_op(16'h1357, 16'h0246, 1'b0, 1'b1, gs, gc, go, lat, bc, w);
        exp = model(16'h1357, 16'h0246, 1'b0, 1'b1);
        tests++;
        if ({go, gc, gs} !== exp) begin
            fails++;
            $display("FAIL b2b_first: got sum=%h, want %h", gs, exp[15:0]);
        end
        run_op(16'h4000, 16'h4000, 1'b0, 1'b0, gs, gc, go, lat, bc, w);
        exp = model(16'h4000, 16'h4000, 1'b0, 1'b0);
        tests++;
        if ({go, gc, gs} !== exp || w != 2 || lat != 5) begin
            fails++;
            $display("FAIL b2b_second: got sum=%h ovf=%b waits=%0d lat=%0d, want sum=%h ovf=%b waits=2 lat=5",
                     gs, go, w, lat, exp[15:0], exp[17]);
        end
    endtask

    task automatic test_ignore_start();
        int          ndone;
        int          cyc;
        logic [15:0] got;
        do @(negedge clk); while (busy || done);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0;
        got = 16'h0;
        cyc = 0;
        while (cyc < 20 && ndone == 0) begin
            cyc++;
            if (done) begin
                ndone++;
                got = sum;
                start = 1'b0;
            end else begin
                start = 1'b1;
                a = (cyc == 1) ? 16'hFFFF : 16'($urandom);
                b = (cyc == 1) ? 16'hFFFF : 16'($urandom);
                sub = 1'($urandom);
                cin = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        tests++;
        if (ndone != 1 || got !== 16'h2345 || cyc != 5) begin
            fails++;
            $display("FAIL ignore_start: got dones=%0d sum=%h done_cycle=%0d, want 1 2345 5",
                     ndone, got, cyc);
        end
    endtask

    task automatic test_reset_mid_run();
        int          ndone;
        logic [15:0] gs;
        logic        gc;
        logic        go;
        int          lat;
        int          bc;
        int          w;
        do @(negedge clk); while (busy || done);
        a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, sum, cout, ovf} !== 19'd0) begin
            fails++;
            $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        ndone = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        tests++;
        if (ndone != 0) begin
            fails++;
            $display("FAIL reset_no_done: got %0d done/busy cycles, want 0", ndone);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, gs, gc, go, lat, bc, w);
        tests++;
        if (gs !== 16'h0002 || gc !== 1'b0 || go !== 1'b0 || lat != 5) begin
            fails++;
            $display("FAIL after_reset: got sum=%h cout=%b ovf=%b lat=%0d, want 0002 0 0 5",
                     gs, gc, go, lat);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
